ibex_mult_pext_sequencer: RTL and testbench

// Multi-cycle sequencer for the Pext/M multiplier path, directly downstream of the op decode helper.

---
 rtl/ibex_pkg_pext.sv | 24 ++
 rtl/ibex_mult_pext_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ibex_mult_pext_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared declarations for the Pext/M multiplier path.
//   mult_pext_mode_e : multiplier mode produced by the op decode helper
//   mult_seq_state_e : state of the multi-cycle multiplier sequencer
//   MULT_CYC_*       : encodings of the decoded cycle count
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    M8x8   = 2'b00,
    M16x16 = 2'b01,
    M32x16 = 2'b10,
    M32x32 = 2'b11
  } mult_pext_mode_e;

  typedef enum logic [1:0] {
    MSEQ_IDLE = 2'b00,
    MSEQ_HI   = 2'b01,
    MSEQ_ACC  = 2'b10
  } mult_seq_state_e;

  localparam logic [1:0] MULT_CYC_1 = 2'b00;
  localparam logic [1:0] MULT_CYC_2 = 2'b01;
  localparam logic [1:0] MULT_CYC_3 = 2'b11;

endpackage

// File: rtl/ibex_mult_pext_sequencer.sv
// Multi-cycle sequencer for the Pext/M multiplier path.
// Steps the external 32x16 array through a low-half pass (B[15:0]) and a
// high-half pass (B[31:16]), combines the partial products into a 64-bit
// product and, for 3-cycle ops, borrows the ALU for one add/sub of the
// selected product word.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   mult_en_i        op request, held by ID until valid_o; dropping it kills the op
//   mult_mode_i      multiplier mode (M32x32 always needs two passes)
//   cycle_count_i    decoded cycle count (00 = 1, 01/10 = 2, 11 = 3 cycles)
//   accum_i          op accumulates into rd (ACC step runs for every 3-cycle op)
//   accum_sub_i      bit[1] selects subtract in the ACC step
//   high_word_i      ACC operand is product[63:32] (1) or product[31:0] (0)
//   partial_i        signed partial product for the current b_half_o
//   alu_result_i     ALU sum/difference while alu_req_o is high
//   b_half_o         operand-B half driven to the array
//   alu_req_o        ALU borrowed this cycle
//   alu_sub_o        ALU computes rd - operand
//   alu_operand_o    accumulation operand
//   result_o         result, zero unless valid_o
//   valid_o          one-cycle result pulse per op
//   busy_o           sequencer not idle
//   state_o          current sequencer state (debug)
//
// Handshake: mult_en_i acts as a level request that is held until the cycle
// in which valid_o is high; valid_o is a single-cycle pulse and result_o is
// only meaningful in that cycle. A new request may be presented in the
// cycle right after valid_o. Deasserting mult_en_i before valid_o aborts.
module ibex_mult_pext_sequencer
  import ibex_pkg_pext::*;
#(
  parameter int unsigned PP_W  = 48,
  parameter int unsigned RES_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mult_en_i,
  input  mult_pext_mode_e      mult_mode_i,
  input  logic [1:0]           cycle_count_i,
  input  logic                 accum_i,
  input  logic [1:0]           accum_sub_i,
  input  logic                 high_word_i,
  input  logic [PP_W-1:0]      partial_i,
  input  logic [31:0]          alu_result_i,
  output logic                 b_half_o,
  output logic                 alu_req_o,
  output logic                 alu_sub_o,
  output logic [31:0]          alu_operand_o,
  output logic [RES_W-1:0]     result_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output mult_seq_state_e      state_o
);

  mult_seq_state_e  state_q;
  logic [RES_W-1:0] prod_q;
  logic [1:0]       cyc_q;

  logic [1:0]       eff_cnt;
  logic [RES_W-1:0] pp_sext;
  logic [RES_W-1:0] pp_shift;
  logic [RES_W-1:0] hi_sum;

  // accum_i does not change sequencing: a 3-cycle op always runs the ACC
  // step and simply forwards the ALU result. accum_sub_i[0] is consumed
  // elsewhere in the datapath.
  logic unused_inputs;
  assign unused_inputs = accum_i ^ accum_sub_i[0];

  // 2'b10 is folded onto the 2-cycle encoding; a full 32x32 product can
  // never be produced by a single 32x16 pass.
  always_comb begin
    eff_cnt = cycle_count_i;
    if (cycle_count_i == 2'b10) begin
      eff_cnt = MULT_CYC_2;
    end
    if ((mult_mode_i == M32x32) && (cycle_count_i == MULT_CYC_1)) begin
      eff_cnt = MULT_CYC_2;
    end
  end

  assign pp_sext  = {{(RES_W-PP_W){partial_i[PP_W-1]}}, partial_i};
  // High-half partial is weighted by 2^16; bits above RES_W are discarded.
  assign pp_shift = {pp_sext[RES_W-17:0], 16'b0};
  assign hi_sum   = prod_q + pp_shift;

  always_comb begin
    b_half_o      = 1'b0;
    alu_req_o     = 1'b0;
    alu_sub_o     = 1'b0;
    alu_operand_o = 32'b0;
    result_o      = '0;
    valid_o       = 1'b0;
    busy_o        = 1'b0;
    unique case (state_q)
      MSEQ_IDLE: begin
        if (mult_en_i && (eff_cnt == MULT_CYC_1)) begin
          result_o = pp_sext;
          valid_o  = 1'b1;
        end
      end
      MSEQ_HI: begin
        busy_o   = 1'b1;
        b_half_o = 1'b1;
        if (mult_en_i && (cyc_q == MULT_CYC_2)) begin
          result_o = hi_sum;
          valid_o  = 1'b1;
        end
      end
      MSEQ_ACC: begin
        busy_o = 1'b1;
        if (mult_en_i) begin
          alu_req_o     = 1'b1;
          alu_sub_o     = accum_sub_i[1];
          alu_operand_o = high_word_i ? prod_q[RES_W-1 -: 32] : prod_q[31:0];
          result_o      = {{(RES_W-32){1'b0}}, alu_result_i};
          valid_o       = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MSEQ_IDLE;
      prod_q  <= '0;
      cyc_q   <= MULT_CYC_1;
    end else begin
      unique case (state_q)
        MSEQ_IDLE: begin
          if (mult_en_i && (eff_cnt != MULT_CYC_1)) begin
            prod_q  <= pp_sext;
            cyc_q   <= eff_cnt;
            state_q <= MSEQ_HI;
          end
        end
        MSEQ_HI: begin
          if (!mult_en_i || (cyc_q != MULT_CYC_3)) begin
            state_q <= MSEQ_IDLE;
          end else begin
            prod_q  <= hi_sum;
            state_q <= MSEQ_ACC;
          end
        end
        MSEQ_ACC: begin
          state_q <= MSEQ_IDLE;
        end
        default: begin
          state_q <= MSEQ_IDLE;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_ibex_mult_pext_sequencer.sv
// Directed testbench for ibex_mult_pext_sequencer.
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising (active) edge.
module tb_ibex_mult_pext_sequencer;
  import ibex_pkg_pext::*;

  logic            clk;
  logic            rst_n;
  logic            mult_en;
  mult_pext_mode_e mult_mode;
  logic [1:0]      cycle_count;
  logic            accum;
  logic [1:0]      accum_sub;
  logic            high_word;
  logic [47:0]     partial;
  logic [31:0]     alu_result;
  logic            b_half;
  logic            alu_req;
  logic            alu_sub;
  logic [31:0]     alu_operand;
  logic [63:0]     result;
  logic            valid;
  logic            busy;
  mult_seq_state_e state;

  int errors = 0;
  int checks = 0;

  ibex_mult_pext_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mult_en_i     (mult_en),
    .mult_mode_i   (mult_mode),
    .cycle_count_i (cycle_count),
    .accum_i       (accum),
    .accum_sub_i   (accum_sub),
    .high_word_i   (high_word),
    .partial_i     (partial),
    .alu_result_i  (alu_result),
    .b_half_o      (b_half),
    .alu_req_o     (alu_req),
    .alu_sub_o     (alu_sub),
    .alu_operand_o (alu_operand),
    .result_o      (result),
    .valid_o       (valid),
    .busy_o        (busy),
    .state_o       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one cycle of input values, applied after the falling edge
  task automatic cyc(input logic en, input mult_pext_mode_e mode, input logic [1:0] cnt,
                     input logic [1:0] sub, input logic hw, input logic [47:0] pp,
                     input logic [31:0] alu_res);
    @(negedge clk);
    mult_en     = en;
    mult_mode   = mode;
    cycle_count = cnt;
    accum       = (cnt == 2'b11);
    accum_sub   = sub;
    high_word   = hw;
    partial     = pp;
    alu_result  = alu_res;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, M16x16, 2'b00, 2'b00, 1'b0, 48'h0, 32'h0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, {63'b0, valid}, 64'h0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'h0);
    chk({tag, "_alu_req"}, {63'b0, alu_req}, 64'h0);
    chk({tag, "_result"}, result, 64'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    mult_en     = 1'b0;
    mult_mode   = M16x16;
    cycle_count = 2'b00;
    accum       = 1'b0;
    accum_sub   = 2'b00;
    high_word   = 1'b0;
    partial     = 48'h0;
    alu_result  = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_b_half", {63'b0, b_half}, 64'h0);
    chk("rst_alu_operand", {32'b0, alu_operand}, 64'h0);
    chk("rst_state", {62'b0, state}, {62'b0, MSEQ_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // count 00: combinational single pass, negative partial sign-extended
    cyc(1'b1, M16x16, 2'b00, 2'b00, 1'b0, 48'hFFFF_FFFF_FFFE, 32'h0);
    chk("c1_valid", {63'b0, valid}, 64'h1);
    chk("c1_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("c1_busy", {63'b0, busy}, 64'h0);
    chk("c1_b_half", {63'b0, b_half}, 64'h0);
    idle_cyc();
    chk_quiet("c1_after");

    // count 01: low pass then high pass
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h1, 32'h0);
    chk("c2_c0_b_half", {63'b0, b_half}, 64'h0);
    chk("c2_c0_valid", {63'b0, valid}, 64'h0);
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h2, 32'h0);
    chk("c2_c1_b_half", {63'b0, b_half}, 64'h1);
    chk("c2_c1_busy", {63'b0, busy}, 64'h1);
    chk("c2_c1_valid", {63'b0, valid}, 64'h1);
    chk("c2_c1_result", result, 64'h2_0001);
    chk("c2_c1_alu_req", {63'b0, alu_req}, 64'h0);

    // back-to-back: count-00 op right after valid_o
    cyc(1'b1, M8x8, 2'b00, 2'b00, 1'b0, 48'h0000_0000_1234, 32'h0);
    chk("b2b_valid", {63'b0, valid}, 64'h1);
    chk("b2b_result", result, 64'h1234);

    // count 01 with negative high partial: 0 + (-1 << 16)
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h0, 32'h0);
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'hFFFF_FFFF_FFFF, 32'h0);
    chk("neg_hi_result", result, 64'hFFFF_FFFF_FFFF_0000);
    idle_cyc();
    chk_quiet("neg_after");

    // count 11, high word, subtract: product 0x5_0000_0000
    cyc(1'b1, M32x32, 2'b11, 2'b10, 1'b1, 48'h0, 32'h0);
    chk("c3_c0_valid", {63'b0, valid}, 64'h0);
    cyc(1'b1, M32x32, 2'b11, 2'b10, 1'b1, 48'h5_0000, 32'h0);
    chk("c3_c1_valid", {63'b0, valid}, 64'h0);
    chk("c3_c1_busy", {63'b0, busy}, 64'h1);
    chk("c3_c1_alu_req", {63'b0, alu_req}, 64'h0);
    cyc(1'b1, M32x32, 2'b11, 2'b10, 1'b1, 48'h0, 32'h7);
    chk("c3_c2_alu_req", {63'b0, alu_req}, 64'h1);
    chk("c3_c2_alu_sub", {63'b0, alu_sub}, 64'h1);
    chk("c3_c2_operand", {32'b0, alu_operand}, 64'h5);
    chk("c3_c2_valid", {63'b0, valid}, 64'h1);
    chk("c3_c2_result", result, 64'h7);
    chk("c3_c2_b_half", {63'b0, b_half}, 64'h0);
    idle_cyc();
    chk_quiet("c3_after");

    // count 11, low word, add: product 0x1234 + (1 << 16) = 0x1_1234
    cyc(1'b1, M32x32, 2'b11, 2'b01, 1'b0, 48'h1234, 32'h0);
    cyc(1'b1, M32x32, 2'b11, 2'b01, 1'b0, 48'h1, 32'h0);
    cyc(1'b1, M32x32, 2'b11, 2'b01, 1'b0, 48'h0, 32'hDEAD_BEEF);
    chk("c3lo_alu_sub", {63'b0, alu_sub}, 64'h0);
    chk("c3lo_operand", {32'b0, alu_operand}, 64'h1_1234);
    chk("c3lo_result", result, 64'hDEAD_BEEF);

    // kill in HI
    cyc(1'b1, M32x32, 2'b11, 2'b10, 1'b1, 48'h1, 32'h0);
    cyc(1'b0, M32x32, 2'b11, 2'b10, 1'b1, 48'h1, 32'h0);
    chk("kill_hi_valid", {63'b0, valid}, 64'h0);
    chk("kill_hi_alu_req", {63'b0, alu_req}, 64'h0);
    chk("kill_hi_result", result, 64'h0);
    cyc(1'b0, M32x32, 2'b11, 2'b10, 1'b1, 48'h1, 32'h9);
    chk_quiet("kill_hi_c2");

    // kill in ACC
    cyc(1'b1, M32x32, 2'b11, 2'b10, 1'b1, 48'h1, 32'h0);
    cyc(1'b1, M32x32, 2'b11, 2'b10, 1'b1, 48'h1, 32'h0);
    cyc(1'b0, M32x32, 2'b11, 2'b10, 1'b1, 48'h0, 32'h9);
    chk("kill_acc_valid", {63'b0, valid}, 64'h0);
    chk("kill_acc_alu_req", {63'b0, alu_req}, 64'h0);
    chk("kill_acc_result", result, 64'h0);
    idle_cyc();
    chk_quiet("kill_acc_after");

    // reset pulsed in HI, then a fresh count-01 op
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h7, 32'h0);
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h7, 32'h0);
    chk("rsthi_pre_busy", {63'b0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rsthi");
    chk("rsthi_b_half", {63'b0, b_half}, 64'h0);
    idle_cyc();
    rst_n = 1'b1;
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h3, 32'h0);
    chk("rsthi_new_c0_valid", {63'b0, valid}, 64'h0);
    cyc(1'b1, M32x16, 2'b01, 2'b00, 1'b0, 48'h4, 32'h0);
    chk("rsthi_new_valid", {63'b0, valid}, 64'h1);
    chk("rsthi_new_result", result, 64'h4_0003);

    // cycle_count 2'b10 folds onto 2 cycles
    cyc(1'b1, M16x16, 2'b10, 2'b00, 1'b0, 48'h1, 32'h0);
    chk("cnt10_c0_valid", {63'b0, valid}, 64'h0);
    cyc(1'b1, M16x16, 2'b10, 2'b00, 1'b0, 48'h1, 32'h0);
    chk("cnt10_c1_valid", {63'b0, valid}, 64'h1);
    chk("cnt10_c1_result", result, 64'h1_0001);
    idle_cyc();
    chk_quiet("cnt10_after");

    // M32x32 with count 00 runs as 2 cycles
    cyc(1'b1, M32x32, 2'b00, 2'b00, 1'b0, 48'h10, 32'h0);
    chk("m32_c0_valid", {63'b0, valid}, 64'h0);
    chk("m32_c0_result", result, 64'h0);
    cyc(1'b1, M32x32, 2'b00, 2'b00, 1'b0, 48'h2, 32'h0);
    chk("m32_c1_valid", {63'b0, valid}, 64'h1);
    chk("m32_c1_result", result, 64'h2_0010);
    idle_cyc();
    chk_quiet("m32_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
